// File: rtl/delay_line_pkg.sv
// Shared helpers for the runtime-programmable delay line.
// Sizing functions and channel-slice helpers.
package delay_line_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MAX_DEPTH  = 16;
    localparam int DEF_CHANNELS   = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int depth_w(input int max_depth);
        return clog2(max_depth) + 1;
    endfunction

    function automatic int lane_lo(input int c, input int w);
        return c * w;
    endfunction

endpackage

// File: rtl/delay_ring_ram.sv
// Simple dual-port ring storage for one delay-line lane.
// Synchronous write, asynchronous read; contents are not reset.
module delay_ring_ram
    import delay_line_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_MAX_DEPTH,
    parameter int ADDR_W     = clog2(DEF_MAX_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/var_delay_line.sv
// Multi-channel delay line with runtime depth 1..MAX_DEPTH.
// Define VAR_DELAY_ZERO_FILL_EN to zero the output while not valid.
module var_delay_line
    import delay_line_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_DEPTH  = DEF_MAX_DEPTH,
    parameter int CHANNELS   = DEF_CHANNELS
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_shift_en,
    input  logic [depth_w(MAX_DEPTH)-1:0]  i_depth,
    input  logic [CHANNELS*DATA_WIDTH-1:0] i_data_in,
    output logic [CHANNELS*DATA_WIDTH-1:0] o_data_out,
    output logic                           o_valid,
    output logic                           o_depth_err
);

    localparam int DEPTH_W = depth_w(MAX_DEPTH);
    localparam int PTR_W   = clog2(MAX_DEPTH);
    localparam int BUS_W   = CHANNELS * DATA_WIDTH;
    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] ONE_D = DEPTH_W'(1);

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] fill_q;
    logic [DEPTH_W-1:0] fill_nxt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               legal;
    logic               change;
    logic               shift;
    logic               valid_nxt;
    logic [BUS_W-1:0]   ram_q;
    logic [BUS_W-1:0]   tap;
    logic [BUS_W-1:0]   out_nxt;

    assign legal  = (i_depth != '0) && (i_depth <= MAX_D);
    assign change = legal && (i_depth != depth_q);
    assign shift  = i_shift_en && !change;

    // Tap sits D-1 writes behind the slot being written this cycle.
    assign rd_ptr = wr_ptr - PTR_W'(depth_q - ONE_D);

    assign fill_nxt  = (fill_q < depth_q) ? fill_q + ONE_D : fill_q;
    assign valid_nxt = (fill_nxt >= depth_q);
    assign tap       = (depth_q == ONE_D) ? i_data_in : ram_q;

    always_comb begin
        out_nxt = tap;
`ifdef VAR_DELAY_ZERO_FILL_EN
        if (!valid_nxt) begin
            out_nxt = '0;
        end
`endif
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        delay_ring_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (MAX_DEPTH),
            .ADDR_W     (PTR_W)
        ) u_ram (
            .i_clk   (i_clk),
            .i_we    (shift),
            .i_waddr (wr_ptr),
            .i_wdata (i_data_in[lane_lo(c, DATA_WIDTH) +: DATA_WIDTH]),
            .i_raddr (rd_ptr),
            .o_rdata (ram_q[lane_lo(c, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            depth_q     <= MAX_D;
            fill_q      <= '0;
            wr_ptr      <= '0;
            o_valid     <= 1'b0;
            o_data_out  <= '0;
            o_depth_err <= 1'b0;
        end else begin
            o_depth_err <= ~legal;
            if (change) begin
                depth_q <= i_depth;
                fill_q  <= '0;
                o_valid <= 1'b0;
`ifdef VAR_DELAY_ZERO_FILL_EN
                o_data_out <= '0;
`endif
            end else if (shift) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                fill_q     <= fill_nxt;
                o_valid    <= valid_nxt;
                o_data_out <= out_nxt;
            end
        end
    end

endmodule

// File: tb/tb_var_delay_line.sv
// Randomized bench for var_delay_line against a queue-based model.
// Two lanes, 16-bit samples, MAX_DEPTH 16.
module tb_var_delay_line;

    localparam int DW = 16;
    localparam int MD = 16;
    localparam int CH = 2;
    localparam int BW = DW * CH;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_shift_en;
    logic [4:0]    i_depth;
    logic [BW-1:0] i_data_in;
    logic [BW-1:0] o_data_out;
    logic          o_valid;
    logic          o_depth_err;

    var_delay_line #(
        .DATA_WIDTH (DW),
        .MAX_DEPTH  (MD),
        .CHANNELS   (CH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_shift_en  (i_shift_en),
        .i_depth     (i_depth),
        .i_data_in   (i_data_in),
        .o_data_out  (o_data_out),
        .o_valid     (o_valid),
        .o_depth_err (o_depth_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    // Model: samples accepted since the last reset / depth change.
    int            dm;
    logic [BW-1:0] hist[$];
    logic          exp_valid;
    logic [BW-1:0] exp_out;
    logic          exp_err;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        dm = MD;
        hist.delete();
        exp_valid = 1'b0;
        exp_out = '0;
        exp_err = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [4:0] dep,
                              input logic [BW-1:0] d);
        bit legal;
        legal = (dep >= 1) && (dep <= MD);
        exp_err = !legal;
        if (legal && int'(dep) != dm) begin
            dm = int'(dep);
            hist.delete();
            exp_valid = 1'b0;
`ifdef VAR_DELAY_ZERO_FILL_EN
            exp_out = '0;
`endif
        end else if (en) begin
            hist.push_back(d);
            if (hist.size() > MD) void'(hist.pop_front());
            if (hist.size() >= dm) begin
                exp_valid = 1'b1;
                exp_out = hist[hist.size() - dm];
            end else begin
                exp_valid = 1'b0;
`ifdef VAR_DELAY_ZERO_FILL_EN
                exp_out = '0;
`endif
            end
        end
    endtask

    always @(negedge i_clk) begin
        if (cmp_en) begin
            chk("valid", 32'(o_valid), 32'(exp_valid));
            chk("depth_err", 32'(o_depth_err), 32'(exp_err));
`ifdef VAR_DELAY_ZERO_FILL_EN
            chk("data", o_data_out, exp_out);
`else
            if (exp_valid) chk("data", o_data_out, exp_out);
`endif
        end
    end

    task automatic cycle(input logic en, input logic [4:0] dep,
                         input logic [BW-1:0] d);
        i_shift_en = en;
        i_depth = dep;
        i_data_in = d;
        @(posedge i_clk);
        model_step(en, dep, d);
        #1;
    endtask

    function automatic logic [BW-1:0] smp(input int k);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = DW'(k);
        b = DW'(k + 16'h1000);
        return {b, a};
    endfunction

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_shift_en = 1'b0;
        i_depth = 5'd16;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", o_data_out, 32'd0);
        chk("rst_err", 32'(o_depth_err), 32'd0);
        model_reset();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        int cur;
        model_reset();
        i_rst_n = 1'b0;
        i_shift_en = 1'b0;
        i_depth = 5'd16;
        i_data_in = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_data", o_data_out, 32'd0);
        i_rst_n = 1'b1;
        cmp_en = 1;

        // Basic delay at D=4.
        cycle(1'b0, 5'd4, '0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 5'd4, smp(k));
            if (k == 3) chk("basic_v3", 32'(o_valid), 32'd0);
            if (k == 4) chk("basic_v4", 32'(o_valid), 32'd1);
            if (k == 4) chk("basic_o4", o_data_out, 32'h1001_0001);
            if (k == 8) chk("basic_o8", o_data_out, 32'h1005_0005);
        end

        // Gapped enable.
        do_reset();
        cycle(1'b0, 5'd4, '0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 5'd4, smp(k));
            cycle(1'b0, 5'd4, smp(k + 500));
            if (k >= 4) chk("gap_hold", 32'(o_data_out[15:0]), 32'(k - 3));
        end

        // Minimum depth.
        cycle(1'b0, 5'd1, '0);
        cycle(1'b1, 5'd1, 32'h55AA_1234);
        chk("min_v", 32'(o_valid), 32'd1);
        chk("min_o", o_data_out, 32'h55AA_1234);
        cycle(1'b1, 5'd1, 32'h0F0F_BEEF);
        chk("min_o2", o_data_out, 32'h0F0F_BEEF);

        // Maximum depth across two wraps.
        cycle(1'b0, 5'd16, '0);
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b1, 5'd16, smp(k));
            if (k == 15) chk("max_v15", 32'(o_valid), 32'd0);
            if (k >= 16) chk("max_o", 32'(o_data_out[15:0]), 32'(k - 15));
        end

        // Depth change mid-stream.
        cycle(1'b0, 5'd4, '0);
        for (int k = 1; k <= 6; k++) cycle(1'b1, 5'd4, smp(k));
        cycle(1'b1, 5'd2, smp(99));
        chk("chg_v0", 32'(o_valid), 32'd0);
        cycle(1'b1, 5'd2, smp(100));
        chk("chg_v1", 32'(o_valid), 32'd0);
        cycle(1'b1, 5'd2, smp(101));
        chk("chg_v2", 32'(o_valid), 32'd1);
        chk("chg_o", o_data_out, 32'h1064_0064);

        // Illegal depths keep D=2.
        cycle(1'b1, 5'd0, smp(200));
        chk("err0", 32'(o_depth_err), 32'd1);
        chk("err0_o", o_data_out, 32'h1065_0065);
        cycle(1'b1, 5'd20, smp(201));
        chk("err20", 32'(o_depth_err), 32'd1);
        chk("err20_o", o_data_out, 32'h10C8_00C8);
        cycle(1'b1, 5'd2, smp(202));
        chk("err_clr", 32'(o_depth_err), 32'd0);
        chk("err_o", o_data_out, 32'h10C9_00C9);
        do_reset();

        // Randomized traffic with independent lanes.
        cur = 16;
        for (int i = 0; i < 600; i++) begin
            logic [4:0] dep;
            logic en;
            en = ($urandom % 4) != 0;
            dep = 5'(cur);
            if (($urandom % 20) == 0) begin
                dep = 5'($urandom_range(0, 20));
                if (dep >= 1 && dep <= 16) cur = int'(dep);
            end
            cycle(en, dep, BW'($urandom));
            if ((i % 200) == 199) begin
                do_reset();
                cur = 16;
            end
        end

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
